// File: rtl/cache_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cache_request_sequencer
// Brief    : Replays a programmable read/write trace into the L1 cache one
//            request at a time, checks read data, counts hits/misses/mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module cache_request_sequencer #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TRACE_DEPTH    = 16,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IDX_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_wr_en,
    input  logic [IDX_W-1:0]         trace_wr_idx,
    input  logic                     trace_wr_op,
    input  logic                     trace_wr_chk,
    input  logic [ADDRESS_WIDTH-1:0] trace_wr_addr,
    input  logic [DATA_WIDTH-1:0]    trace_wr_data,
    input  logic [7:0]               trace_length,
    input  logic                     start,
    output logic                     cache_read_request,
    output logic                     cache_write_request,
    output logic [ADDRESS_WIDTH-1:0] cache_L1_memory_address,
    output logic [DATA_WIDTH-1:0]    cache_write_data,
    input  logic                     L1_cache_ready,
    input  logic                     L1_cache_hit,
    input  logic                     L1_cache_miss,
    input  logic [DATA_WIDTH-1:0]    cache_read_data,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_error,
    output logic [7:0]               hit_count,
    output logic [7:0]               miss_count,
    output logic [7:0]               mismatch_count,
    output logic [DATA_WIDTH-1:0]    last_read_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_GAP   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam int                WAIT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        C_DEPTH     = 8'(TRACE_DEPTH);

    state_t              r_state;
    logic [7:0]          r_idx;
    logic [7:0]          r_len;
    logic [WAIT_W-1:0]   r_wait;

    logic                     r_trace_op   [TRACE_DEPTH];
    logic                     r_trace_chk  [TRACE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_trace_addr [TRACE_DEPTH];
    logic [DATA_WIDTH-1:0]    r_trace_data [TRACE_DEPTH];

    logic                     w_can_cfg;
    logic                     w_wr;
    logic                     w_fwd0;
    logic [7:0]               w_len;
    logic [7:0]               w_idx_inc;
    logic                     w_last_entry;
    logic                     w_cur_chk;
    logic [DATA_WIDTH-1:0]    w_cur_exp;
    logic                     w_ld_op;
    logic [ADDRESS_WIDTH-1:0] w_ld_addr;
    logic [DATA_WIDTH-1:0]    w_ld_data;

    assign w_can_cfg    = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign w_wr         = trace_wr_en && w_can_cfg && (32'(trace_wr_idx) < TRACE_DEPTH);
    assign w_fwd0       = w_wr && (trace_wr_idx == '0);
    assign w_len        = (32'(trace_length) > TRACE_DEPTH) ? C_DEPTH : trace_length;
    assign w_idx_inc    = r_idx + 8'd1;
    assign w_last_entry = (r_idx == (r_len - 8'd1));
    assign w_cur_chk    = r_trace_chk[r_idx[IDX_W-1:0]];
    assign w_cur_exp    = r_trace_data[r_idx[IDX_W-1:0]];

    // Trace storage is deliberately not reset; software reloads it after reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_trace_op[trace_wr_idx]   <= trace_wr_op;
            r_trace_chk[trace_wr_idx]  <= trace_wr_chk;
            r_trace_addr[trace_wr_idx] <= trace_wr_addr;
            r_trace_data[trace_wr_idx] <= trace_wr_data;
        end
    end

    // Entry to launch: the next entry from GAP, else entry 0 on start with a
    // same-cycle write to entry 0 forwarded so replay sees post-write contents.
    always_comb begin
        w_ld_op   = r_trace_op[w_idx_inc[IDX_W-1:0]];
        w_ld_addr = r_trace_addr[w_idx_inc[IDX_W-1:0]];
        w_ld_data = r_trace_data[w_idx_inc[IDX_W-1:0]];
        if (r_state != ST_GAP) begin
            if (w_fwd0) begin
                w_ld_op   = trace_wr_op;
                w_ld_addr = trace_wr_addr;
                w_ld_data = trace_wr_data;
            end else begin
                w_ld_op   = r_trace_op[0];
                w_ld_addr = r_trace_addr[0];
                w_ld_data = r_trace_data[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state                 <= ST_IDLE;
            r_idx                   <= '0;
            r_len                   <= '0;
            r_wait                  <= '0;
            cache_read_request      <= 1'b0;
            cache_write_request     <= 1'b0;
            cache_L1_memory_address <= '0;
            cache_write_data        <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            timeout_error           <= 1'b0;
            hit_count               <= '0;
            miss_count              <= '0;
            mismatch_count          <= '0;
            last_read_data          <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        hit_count      <= '0;
                        miss_count     <= '0;
                        mismatch_count <= '0;
                        timeout_error  <= 1'b0;
                        r_idx          <= '0;
                        r_wait         <= '0;
                        r_len          <= w_len;
                        if (w_len == 8'd0) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state                 <= ST_REQ;
                            done                    <= 1'b0;
                            busy                    <= 1'b1;
                            cache_read_request      <= ~w_ld_op;
                            cache_write_request     <= w_ld_op;
                            cache_L1_memory_address <= w_ld_addr;
                            if (w_ld_op) begin
                                cache_write_data <= w_ld_data;
                            end
                        end
                    end
                end

                ST_REQ: begin
                    if (L1_cache_ready) begin
                        if (L1_cache_hit) begin
                            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
                        end else if (L1_cache_miss) begin
                            if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
                        end
                        if (cache_read_request) begin
                            last_read_data <= cache_read_data;
                            if (w_cur_chk && (cache_read_data != w_cur_exp) && (mismatch_count != 8'hFF)) begin
                                mismatch_count <= mismatch_count + 8'd1;
                            end
                        end
                        cache_read_request  <= 1'b0;
                        cache_write_request <= 1'b0;
                        if (w_last_entry) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else if (r_wait == C_WAIT_LAST) begin
                        r_state             <= ST_ERROR;
                        cache_read_request  <= 1'b0;
                        cache_write_request <= 1'b0;
                        timeout_error       <= 1'b1;
                        busy                <= 1'b0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                ST_GAP: begin
                    r_idx                   <= w_idx_inc;
                    r_wait                  <= '0;
                    r_state                 <= ST_REQ;
                    cache_read_request      <= ~w_ld_op;
                    cache_write_request     <= w_ld_op;
                    cache_L1_memory_address <= w_ld_addr;
                    if (w_ld_op) begin
                        cache_write_data <= w_ld_data;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
